// File: rtl/abr_prim_fifo_ptr_ctrl.sv
// abr_prim_fifo_ptr_ctrl
// Multi-channel FIFO pointer controller. Every channel owns a phase-tagged
// write pointer and read pointer ({phase, addr}) that address a shared
// storage macro. Depth may be any value >= 2, including non-powers of two:
// the address wraps at Depth-1 and toggles the phase bit. Status flags and
// the fill level are decoded only from registers. In Secure mode each
// pointer is shadowed by its complement and the pair is cross-checked every
// cycle, with a sticky err_o cleared only by reset.

module abr_prim_fifo_ptr_ctrl #(
    parameter int unsigned Depth         = 4,
    parameter int unsigned NumCh         = 2,
    parameter int unsigned AlmostFullThr = Depth - 1,
    parameter bit          Secure        = 1'b0,
    localparam int unsigned AddrW        = (Depth > 2) ? $clog2(Depth) : 1,
    localparam int unsigned PtrW         = AddrW + 1,
    localparam int unsigned CntW         = $clog2(Depth + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_b,
    input  logic [NumCh-1:0]       clr_i,
    input  logic [NumCh-1:0]       wr_en_i,
    input  logic [NumCh-1:0]       rd_en_i,
    output logic [NumCh-1:0]       wr_ack_o,
    output logic [NumCh-1:0]       rd_ack_o,
    output logic [NumCh*AddrW-1:0] waddr_o,
    output logic [NumCh*AddrW-1:0] raddr_o,
    output logic [NumCh*CntW-1:0]  depth_o,
    output logic [NumCh-1:0]       full_o,
    output logic [NumCh-1:0]       empty_o,
    output logic [NumCh-1:0]       almost_full_o,
    output logic [NumCh-1:0]       ovf_o,
    output logic [NumCh-1:0]       udf_o,
    output logic                   err_o
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

    logic [NumCh-1:0][PtrW-1:0] wptr_q, wptr_d;
    logic [NumCh-1:0][PtrW-1:0] rptr_q, rptr_d;
    logic [NumCh-1:0][PtrW-1:0] wshadow_q, wshadow_d;
    logic [NumCh-1:0][PtrW-1:0] rshadow_q, rshadow_d;
    logic [NumCh-1:0]           ovf_q, ovf_d;
    logic [NumCh-1:0]           udf_q, udf_d;
    logic                       err_q, err_d;

    logic [NumCh-1:0]           full;
    logic [NumCh-1:0]           empty;
    logic                       integ_fail;

    // Advance a pointer by one entry, wrapping at Depth-1 and flipping phase.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [AddrW-1:0] addr;
        logic             phase;
        addr  = ptr[AddrW-1:0];
        phase = ptr[PtrW-1];
        if (addr == LastAddr) begin
            addr  = '0;
            phase = ~phase;
        end else begin
            addr = addr + 1'b1;
        end
        return {phase, addr};
    endfunction

    // Decode addresses, fill level and status flags from the pointer registers.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        full          = '0;
        empty         = '0;
        waddr_o       = '0;
        raddr_o       = '0;
        depth_o       = '0;
        almost_full_o = '0;
        for (int c = 0; c < NumCh; c++) begin
            logic [AddrW-1:0] wa;
            logic [AddrW-1:0] ra;
            logic [CntW-1:0]  wa_ext;
            logic [CntW-1:0]  ra_ext;
            logic [CntW-1:0]  level;
            logic             same_phase;
            wa         = wptr_q[c][AddrW-1:0];
            ra         = rptr_q[c][AddrW-1:0];
            wa_ext     = CntW'(wa);
            ra_ext     = CntW'(ra);
            same_phase = (wptr_q[c][PtrW-1] == rptr_q[c][PtrW-1]);
            empty[c]   = (wptr_q[c] == rptr_q[c]);
            full[c]    = (wa == ra) && !same_phase;
            level      = same_phase ? (wa_ext - ra_ext)
                                    : (CntW'(Depth) - ra_ext + wa_ext);
            waddr_o[c*AddrW +: AddrW] = wa;
            raddr_o[c*AddrW +: AddrW] = ra;
            depth_o[c*CntW +: CntW]   = level;
            almost_full_o[c]          = (level >= CntW'(AlmostFullThr));
        end
    end

    assign empty_o  = empty;
    assign full_o   = full;
    assign wr_ack_o = wr_en_i & ~full;
    assign rd_ack_o = rd_en_i & ~empty;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;
    assign err_o    = Secure ? err_q : 1'b0;

    // Next-state pointers and sticky flags; clear wins over push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        for (int c = 0; c < NumCh; c++) begin
            if (clr_i[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                ovf_d[c]  = 1'b0;
                udf_d[c]  = 1'b0;
            end else begin
                if (wr_en_i[c] && !full[c]) begin
                    wptr_d[c] = ptr_inc(wptr_q[c]);
                end
                if (rd_en_i[c] && !empty[c]) begin
                    rptr_d[c] = ptr_inc(rptr_q[c]);
                end
                ovf_d[c] = ovf_q[c] | (wr_en_i[c] & full[c]);
                udf_d[c] = udf_q[c] | (rd_en_i[c] & empty[c]);
            end
        end
        wshadow_d = ~wptr_d;
        rshadow_d = ~rptr_d;
    end

    // Integrity check: shadow must be the complement and addr must be in range.
    always_comb begin
        integ_fail = 1'b0;
        for (int c = 0; c < NumCh; c++) begin
            if ((wptr_q[c] != ~wshadow_q[c]) || (rptr_q[c] != ~rshadow_q[c])) begin
                integ_fail = 1'b1;
            end
            if ((wptr_q[c][AddrW-1:0] > LastAddr) || (rptr_q[c][AddrW-1:0] > LastAddr)) begin
                integ_fail = 1'b1;
            end
        end
        err_d = err_q | (Secure & integ_fail);
    end

    // State registers; shadows reset to all-ones, the complement of zero.
    always_ff @(posedge clk_i or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_b) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            wshadow_q <= '1;
            rshadow_q <= '1;
            ovf_q     <= '0;
            udf_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wshadow_q <= wshadow_d;
            rshadow_q <= rshadow_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_abr_prim_fifo_ptr_ctrl.sv
// Testbench for abr_prim_fifo_ptr_ctrl. The main instance (Depth=5, NumCh=2,
// Secure=1) is driven one cycle at a time; each cycle pushes the expected
// visible response into a scoreboard queue, computed from a counting model
// (total accepted pushes/pops per channel). A monitor pops and compares on
// every falling edge. A second instance (Depth=4, NumCh=1, Secure=0) covers
// the power-of-two wrap case and the non-secure tie-off of err_o.

module tb_abr_prim_fifo_ptr_ctrl;

    localparam int D  = 5;
    localparam int NC = 2;
    localparam int AW = 3;
    localparam int CW = 3;
    localparam int AF = D - 1;

    typedef struct packed {
        logic [NC-1:0]    wr_ack;
        logic [NC-1:0]    rd_ack;
        logic [NC*AW-1:0] waddr;
        logic [NC*AW-1:0] raddr;
        logic [NC*CW-1:0] depth;
        logic [NC-1:0]    full;
        logic [NC-1:0]    empty;
        logic [NC-1:0]    af;
        logic [NC-1:0]    ovf;
        logic [NC-1:0]    udf;
        logic             err;
    } exp_t;

    logic clk;
    logic rst_b;

    logic [NC-1:0]    clr_i, wr_en_i, rd_en_i;
    logic [NC-1:0]    wr_ack_o, rd_ack_o;
    logic [NC*AW-1:0] waddr_o, raddr_o;
    logic [NC*CW-1:0] depth_o;
    logic [NC-1:0]    full_o, empty_o, almost_full_o, ovf_o, udf_o;
    logic             err_o;

    logic       ns_clr, ns_wr, ns_rd;
    logic       ns_wr_ack, ns_rd_ack;
    logic [1:0] ns_waddr, ns_raddr;
    logic [2:0] ns_depth;
    logic       ns_full, ns_empty, ns_af, ns_ovf, ns_udf, ns_err;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];

    int wr_cnt[NC];
    int rd_cnt[NC];
    bit ovf_m[NC];
    bit udf_m[NC];
    bit err_m;

    abr_prim_fifo_ptr_ctrl #(.Depth(D), .NumCh(NC), .Secure(1'b1)) dut (
        .clk_i(clk), .rst_b(rst_b), .clr_i(clr_i), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
        .wr_ack_o(wr_ack_o), .rd_ack_o(rd_ack_o), .waddr_o(waddr_o), .raddr_o(raddr_o),
        .depth_o(depth_o), .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
        .ovf_o(ovf_o), .udf_o(udf_o), .err_o(err_o)
    );

    abr_prim_fifo_ptr_ctrl #(.Depth(4), .NumCh(1), .Secure(1'b0)) dut_ns (
        .clk_i(clk), .rst_b(rst_b), .clr_i(ns_clr), .wr_en_i(ns_wr), .rd_en_i(ns_rd),
        .wr_ack_o(ns_wr_ack), .rd_ack_o(ns_rd_ack), .waddr_o(ns_waddr), .raddr_o(ns_raddr),
        .depth_o(ns_depth), .full_o(ns_full), .empty_o(ns_empty), .almost_full_o(ns_af),
        .ovf_o(ns_ovf), .udf_o(ns_udf), .err_o(ns_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            wr_cnt[c] = 0;
            rd_cnt[c] = 0;
            ovf_m[c]  = 1'b0;
            udf_m[c]  = 1'b0;
        end
        err_m = 1'b0;
    endtask

    // Apply one cycle of stimulus, queue the expected visible response and
    // advance the model by the operations that cycle will commit.
    task automatic cycle(input logic [NC-1:0] c, input logic [NC-1:0] w, input logic [NC-1:0] r);
        exp_t e;
        @(posedge clk);
        #2;
        clr_i   = c;
        wr_en_i = w;
        rd_en_i = r;
        e = '0;
        for (int ch = 0; ch < NC; ch++) begin
            int  level;
            bit  is_full;
            bit  is_empty;
            level    = wr_cnt[ch] - rd_cnt[ch];
            is_full  = (level == D);
            is_empty = (level == 0);
            e.wr_ack[ch]          = w[ch] && !is_full;
            e.rd_ack[ch]          = r[ch] && !is_empty;
            e.waddr[ch*AW +: AW]  = AW'(wr_cnt[ch] % D);
            e.raddr[ch*AW +: AW]  = AW'(rd_cnt[ch] % D);
            e.depth[ch*CW +: CW]  = CW'(level);
            e.full[ch]            = is_full;
            e.empty[ch]           = is_empty;
            e.af[ch]              = (level >= AF);
            e.ovf[ch]             = ovf_m[ch];
            e.udf[ch]             = udf_m[ch];
            if (c[ch]) begin
                wr_cnt[ch] = 0;
                rd_cnt[ch] = 0;
                ovf_m[ch]  = 1'b0;
                udf_m[ch]  = 1'b0;
            end else begin
                if (w[ch] && !is_full) wr_cnt[ch]++;
                if (w[ch] && is_full)  ovf_m[ch] = 1'b1;
                if (r[ch] && !is_empty) rd_cnt[ch]++;
                if (r[ch] && is_empty)  udf_m[ch] = 1'b1;
            end
        end
        e.err = err_m;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_wr_ack", 32'(wr_ack_o), 32'(e.wr_ack));
                check("sb_rd_ack", 32'(rd_ack_o), 32'(e.rd_ack));
                check("sb_waddr",  32'(waddr_o),  32'(e.waddr));
                check("sb_raddr",  32'(raddr_o),  32'(e.raddr));
                check("sb_depth",  32'(depth_o),  32'(e.depth));
                check("sb_full",   32'(full_o),   32'(e.full));
                check("sb_empty",  32'(empty_o),  32'(e.empty));
                check("sb_af",     32'(almost_full_o), 32'(e.af));
                check("sb_ovf",    32'(ovf_o),    32'(e.ovf));
                check("sb_udf",    32'(udf_o),    32'(e.udf));
                check("sb_err",    32'(err_o),    32'(e.err));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_waddr"}, 32'(waddr_o), 32'h0);
        check({tag, "_raddr"}, 32'(raddr_o), 32'h0);
        check({tag, "_depth"}, 32'(depth_o), 32'h0);
        check({tag, "_empty"}, 32'(empty_o), 32'h3);
        check({tag, "_full"},  32'(full_o),  32'h0);
        check({tag, "_af"},    32'(almost_full_o), 32'h0);
        check({tag, "_ovf"},   32'(ovf_o),   32'h0);
        check({tag, "_udf"},   32'(udf_o),   32'h0);
        check({tag, "_err"},   32'(err_o),   32'h0);
    endtask

    logic [2*(AW+1)-1:0] force_main;
    logic [2:0]          force_ns;

    initial begin
        rst_b   = 1'b0;
        clr_i   = '0;
        wr_en_i = '0;
        rd_en_i = '0;
        ns_clr  = 1'b0;
        ns_wr   = 1'b0;
        ns_rd   = 1'b0;
        model_reset();
        #1;
        check_reset_values("reset");
        @(negedge clk);
        #2;
        rst_b = 1'b1;

        // Fill ch0: almost_full after the 4th push, full after the 5th.
        repeat (5) cycle(2'b00, 2'b01, 2'b00);
        #1;
        check("af_at_4", 32'(almost_full_o[0]), 32'h1);
        check("full_at_4", 32'(full_o[0]), 32'h0);
        cycle(2'b00, 2'b00, 2'b00);
        #1;
        check("full_at_5", 32'(full_o[0]), 32'h1);
        check("depth_at_5", 32'(depth_o[CW-1:0]), 32'h5);
        check("ch1_empty", 32'(empty_o[1]), 32'h1);

        // Push and pop together on a full channel.
        cycle(2'b00, 2'b01, 2'b01);
        #1;
        check("full_wr_ack", 32'(wr_ack_o[0]), 32'h0);
        check("full_rd_ack", 32'(rd_ack_o[0]), 32'h1);
        cycle(2'b00, 2'b00, 2'b00);
        #1;
        check("ovf_set", 32'(ovf_o[0]), 32'h1);
        check("depth_after_ovf", 32'(depth_o[CW-1:0]), 32'h4);
        check("full_after_ovf", 32'(full_o[0]), 32'h0);

        // Drain ch0 and wrap it once more to return the phase to zero.
        repeat (4) cycle(2'b00, 2'b00, 2'b01);
        repeat (5) cycle(2'b00, 2'b01, 2'b00);
        repeat (5) cycle(2'b00, 2'b00, 2'b01);

        // Push and pop together on empty ch1, then clear ch1 only.
        cycle(2'b00, 2'b10, 2'b10);
        #1;
        check("empty_rd_ack", 32'(rd_ack_o[1]), 32'h0);
        check("empty_wr_ack", 32'(wr_ack_o[1]), 32'h1);
        cycle(2'b00, 2'b00, 2'b00);
        #1;
        check("udf_set", 32'(udf_o[1]), 32'h1);
        check("depth_after_udf", 32'(depth_o[2*CW-1:CW]), 32'h1);
        cycle(2'b10, 2'b00, 2'b00);
        cycle(2'b00, 2'b00, 2'b00);
        #1;
        check("clr_depth", 32'(depth_o[2*CW-1:CW]), 32'h0);
        check("clr_udf", 32'(udf_o[1]), 32'h0);
        check("clr_keeps_ch0_ovf", 32'(ovf_o[0]), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [NC-1:0] c;
            c = ($urandom_range(0, 15) == 0) ? NC'($urandom_range(1, 3)) : '0;
            cycle(c, NC'($urandom), NC'($urandom));
        end
        cycle(2'b00, 2'b00, 2'b00);

        // Flip one write-shadow bit for one cycle on both instances.
        @(negedge clk);
        #1;
        force_main = dut.wshadow_q ^ 8'h01;
        force_ns   = dut_ns.wshadow_q ^ 3'h1;
        force dut.wshadow_q    = force_main;
        force dut_ns.wshadow_q = force_ns;
        @(negedge clk);
        #1;
        release dut.wshadow_q;
        release dut_ns.wshadow_q;
        err_m = 1'b1;
        check("err_set", 32'(err_o), 32'h1);
        check("ns_err_tied", 32'(ns_err), 32'h0);
        cycle(2'b11, 2'b00, 2'b00);
        cycle(2'b00, 2'b00, 2'b00);
        #1;
        check("err_survives_clr", 32'(err_o), 32'h1);
        check("ns_err_still_0", 32'(ns_err), 32'h0);

        // Depth=4 instance: 3 entries, then 20 cycles of push+pop.
        @(posedge clk);
        #2;
        ns_clr = 1'b0;
        ns_wr  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("ns_depth_3", 32'(ns_depth), 32'h3);
        ns_rd = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #2;
            check("ns_steady_depth", 32'(ns_depth), 32'h3);
            check("ns_waddr", 32'(ns_waddr), 32'((3 + k) % 4));
            check("ns_raddr", 32'(ns_raddr), 32'(k % 4));
            check("ns_acks", 32'({ns_wr_ack, ns_rd_ack}), 32'h3);
        end
        ns_wr = 1'b0;
        ns_rd = 1'b0;

        // Asynchronous reset mid-cycle while ch0 is half full.
        cycle(2'b11, 2'b00, 2'b00);
        repeat (2) cycle(2'b00, 2'b01, 2'b00);
        cycle(2'b00, 2'b00, 2'b00);
        @(negedge clk);
        #1;
        check("pre_reset_depth", 32'(depth_o[CW-1:0]), 32'h2);
        #1;
        rst_b = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        rst_b = 1'b1;

        // Resume after reset.
        for (int i = 0; i < 30; i++) begin
            cycle(2'b00, NC'($urandom), NC'($urandom));
        end
        cycle(2'b00, 2'b00, 2'b00);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
